// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential BNN classifier.
// No ports: state enum plus constant functions used for sizing.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_L1,
    ST_L2,
    ST_DONE
  } state_t;

  function automatic int sum_width(
    input int fbits,
    input int fcnt
  );
    return fbits + $clog2(fcnt) + 1;
  endfunction

  function automatic int score_width(
    input int hcnt
  );
    return $clog2(hcnt + 1);
  endfunction

  function automatic int group_count(
    input int hcnt,
    input int npar
  );
    return hcnt / npar;
  endfunction

  function automatic int idx_width(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnn_l1_neuron.sv
// One layer-1 binary neuron: signed +/-feature sum and its sign bit.
// Ports: i_features (packed features), i_weights (1=+1), o_act (sum>=0).
module bnn_l1_neuron
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT  = 16,
  parameter int FEAT_BITS = 4
) (
  input  logic [FEAT_CNT*FEAT_BITS-1:0] i_features,
  input  logic [FEAT_CNT-1:0]           i_weights,
  output logic                          o_act
);

  localparam int SW = sum_width(FEAT_BITS, FEAT_CNT);

  logic signed [SW-1:0] w_acc;
  logic signed [SW-1:0] w_f;

  always_comb begin
    w_acc = '0;
    w_f   = '0;
    for (int i = 0; i < FEAT_CNT; i++) begin
      w_f = SW'(i_features[i*FEAT_BITS +: FEAT_BITS]);
      if (i_weights[i])
        w_acc = w_acc + w_f;
      else
        w_acc = w_acc - w_f;
    end
  end

  // A zero sum counts as active.
  assign o_act = ~w_acc[SW-1];

endmodule

// File: rtl/bnn_seq_classifier.sv
// Time-multiplexed 2-layer BNN: NPAR hidden neurons per cycle, then one
// class per cycle with running argmax. Ports: valid/ready in and out,
// features in, prediction + hidden activation bits out.
module bnn_seq_classifier
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT   = 16,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 10,
  parameter int NPAR       = 8,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W0 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W1 = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [((CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1)-1:0] prediction,
  output logic [HIDDEN_CNT-1:0]         hidden
);

  localparam int SCW  = score_width(HIDDEN_CNT);
  localparam int GRPS = group_count(HIDDEN_CNT, NPAR);
  localparam int GW   = idx_width(GRPS);
  localparam int CW   = idx_width(CLASS_CNT);
  localparam logic [GW-1:0] GRP_LAST = GW'(GRPS - 1);
  localparam logic [CW-1:0] CLS_LAST = CW'(CLASS_CNT - 1);

  if (HIDDEN_CNT % NPAR != 0) begin : g_bad_npar
    $error("HIDDEN_CNT must be a multiple of NPAR");
  end

  state_t                        r_state;
  logic [FEAT_CNT*FEAT_BITS-1:0] r_feat;
  logic [GW-1:0]                 r_grp;
  logic [CW-1:0]                 r_cls;
  logic [CW-1:0]                 r_best;
  logic [SCW-1:0]                r_bestscore;
  logic [HIDDEN_CNT-1:0]         r_hidden;
  logic [CW-1:0]                 r_pred;
  logic                          r_in_ready;
  logic                          r_out_valid;

  logic [31:0]               w_w0_base;
  logic [31:0]               w_hbase;
  logic [NPAR*FEAT_CNT-1:0]  w_w0_grp;
  logic [NPAR-1:0]           w_act;
  logic [31:0]               w_w1_base;
  logic [HIDDEN_CNT-1:0]     w_w1_row;
  logic [HIDDEN_CNT-1:0]     w_match;
  logic [SCW-1:0]            w_score;
  logic                      w_upd;
  logic [CW-1:0]             w_best_nxt;

  // Layer 1: W0 rows of the current group feed the NPAR neurons.
  assign w_w0_base = 32'(r_grp) * 32'(NPAR * FEAT_CNT);
  assign w_hbase   = 32'(r_grp) * 32'(NPAR);
  assign w_w0_grp  = W0[w_w0_base +: NPAR*FEAT_CNT];

  for (genvar k = 0; k < NPAR; k++) begin : g_neuron
    bnn_l1_neuron #(
      .FEAT_CNT  (FEAT_CNT),
      .FEAT_BITS (FEAT_BITS)
    ) u_neuron (
      .i_features (r_feat),
      .i_weights  (w_w0_grp[k*FEAT_CNT +: FEAT_CNT]),
      .o_act      (w_act[k])
    );
  end

  // Layer 2: XNOR-popcount against the current class row.
  assign w_w1_base = 32'(r_cls) * 32'(HIDDEN_CNT);
  assign w_w1_row  = W1[w_w1_base +: HIDDEN_CNT];
  assign w_match   = ~(r_hidden ^ w_w1_row);

  always_comb begin
    w_score = '0;
    for (int h = 0; h < HIDDEN_CNT; h++)
      w_score = w_score + SCW'(w_match[h]);
  end

  // Strict compare keeps the lowest index on ties.
  assign w_upd      = (r_cls == '0) || (w_score > r_bestscore);
  assign w_best_nxt = w_upd ? r_cls : r_best;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_feat      <= '0;
      r_grp       <= '0;
      r_cls       <= '0;
      r_best      <= '0;
      r_bestscore <= '0;
      r_hidden    <= '0;
      r_pred      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_feat     <= features;
            r_grp      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_L1;
          end
        end
        ST_L1: begin
          r_hidden[w_hbase +: NPAR] <= w_act;
          if (r_grp == GRP_LAST) begin
            r_grp       <= '0;
            r_cls       <= '0;
            r_best      <= '0;
            r_bestscore <= '0;
            r_state     <= ST_L2;
          end else begin
            r_grp <= r_grp + GW'(1);
          end
        end
        ST_L2: begin
          if (w_upd) begin
            r_best      <= r_cls;
            r_bestscore <= w_score;
          end
          if (r_cls == CLS_LAST) begin
            r_pred      <= w_best_nxt;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cls <= r_cls + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign prediction = r_pred;
  assign hidden     = r_hidden;

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Self-checking bench for bnn_seq_classifier: three weight sets,
// directed table, handshake corners, and randomized model compare.
module tb_bnn_seq_classifier;

  localparam logic [639:0] W0A = {640{1'b1}};
  localparam logic [399:0] W1A = {240'd0, 40'hFF_FFFF_FFFF, 120'd0};
  localparam logic [639:0] W0B = '0;
  localparam logic [399:0] W1B = '0;
  localparam logic [639:0] W0C = {{25{25'h1A5F3C7}}, 15'h2B3E};
  localparam logic [399:0] W1C = {{23{17'h1B3C5}}, 9'h15A};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] features = '0;

  logic        rdy [3];
  logic        vld [3];
  logic [3:0]  pred [3];
  logic [39:0] hid [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bnn_seq_classifier #(.W0(W0A), .W1(W1A)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .features(features), .out_valid(vld[0]), .out_ready(out_ready),
    .prediction(pred[0]), .hidden(hid[0])
  );
  bnn_seq_classifier #(.W0(W0B), .W1(W1B)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .features(features), .out_valid(vld[1]), .out_ready(out_ready),
    .prediction(pred[1]), .hidden(hid[1])
  );
  bnn_seq_classifier #(.W0(W0C), .W1(W1C)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .features(features), .out_valid(vld[2]), .out_ready(out_ready),
    .prediction(pred[2]), .hidden(hid[2])
  );

  typedef struct {
    logic [63:0] feat;
    logic [39:0] hid_a;
    logic [3:0]  pred_a;
    logic [39:0] hid_b;
    logic [3:0]  pred_b;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: signed weighted sums, sign threshold, XNOR-match argmax.
  task automatic model(input int k, input logic [63:0] f,
                       output logic [39:0] h, output logic [3:0] p);
    logic [639:0] w0;
    logic [399:0] w1;
    int s, fv, sc, best, bs;
    w0 = (k == 0) ? W0A : (k == 1) ? W0B : W0C;
    w1 = (k == 0) ? W1A : (k == 1) ? W1B : W1C;
    h = '0;
    for (int hh = 0; hh < 40; hh++) begin
      s = 0;
      for (int i = 0; i < 16; i++) begin
        fv = int'(f[i*4 +: 4]);
        s += w0[hh*16+i] ? fv : -fv;
      end
      h[hh] = (s >= 0);
    end
    best = 0;
    bs = -1;
    for (int c = 0; c < 10; c++) begin
      sc = 0;
      for (int hh = 0; hh < 40; hh++)
        if (h[hh] == w1[c*40+hh]) sc++;
      if (sc > bs) begin
        bs = sc;
        best = c;
      end
    end
    p = 4'(best);
  endtask

  task automatic accept_and_wait(input logic [63:0] f);
    int g;
    int cyc;
    g = 0;
    @(negedge clk);
    while (!rdy[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_idle", {63'd0, rdy[0]}, 64'd1);
    in_valid = 1'b1;
    features = f;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", {61'd0, rdy[0], rdy[1], rdy[2]}, 64'd0);
    cyc = 0;
    while (!vld[0] && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency", 64'(cyc), 64'd15);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_out_valid", {61'd0, vld[0], vld[1], vld[2]}, 64'd0);
    chk("rel_in_ready", {61'd0, rdy[0], rdy[1], rdy[2]}, 64'd7);
  endtask

  task automatic check_all(input logic [63:0] f);
    logic [39:0] eh;
    logic [3:0]  ep;
    for (int k = 0; k < 3; k++) begin
      model(k, f, eh, ep);
      chk($sformatf("hidden_%0d", k), 64'(hid[k]), 64'(eh));
      chk($sformatf("pred_%0d", k), 64'(pred[k]), 64'(ep));
    end
  endtask

  initial begin
    logic [63:0] f;
    logic [39:0] eh;
    logic [3:0]  ep;
    int first, second;

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 4'd3,
               40'h0, 4'd0};
    tbl[1] = '{64'h0, 40'hFF_FFFF_FFFF, 4'd3,
               40'hFF_FFFF_FFFF, 4'd0};
    tbl[2] = '{64'h1, 40'hFF_FFFF_FFFF, 4'd3, 40'h0, 4'd0};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready_%0d", k), {63'd0, rdy[k]}, 64'd1);
      chk($sformatf("rst_out_valid_%0d", k), {63'd0, vld[k]}, 64'd0);
      chk($sformatf("rst_pred_%0d", k), 64'(pred[k]), 64'd0);
      chk($sformatf("rst_hidden_%0d", k), 64'(hid[k]), 64'd0);
    end
    rst_n = 1'b1;

    for (int t = 0; t < 3; t++) begin
      accept_and_wait(tbl[t].feat);
      chk($sformatf("tbl%0d_hid_a", t), 64'(hid[0]), 64'(tbl[t].hid_a));
      chk($sformatf("tbl%0d_pred_a", t), 64'(pred[0]), 64'(tbl[t].pred_a));
      chk($sformatf("tbl%0d_hid_b", t), 64'(hid[1]), 64'(tbl[t].hid_b));
      chk($sformatf("tbl%0d_pred_b", t), 64'(pred[1]), 64'(tbl[t].pred_b));
      model(2, tbl[t].feat, eh, ep);
      chk($sformatf("tbl%0d_hid_c", t), 64'(hid[2]), 64'(eh));
      chk($sformatf("tbl%0d_pred_c", t), 64'(pred[2]), 64'(ep));
      release_out();
    end

    // Backpressure: result must hold for 20 cycles.
    f = {$urandom, $urandom};
    model(2, f, eh, ep);
    accept_and_wait(f);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", {63'd0, vld[2]}, 64'd1);
      chk("bp_in_ready", {63'd0, rdy[2]}, 64'd0);
      chk("bp_pred", 64'(pred[2]), 64'(ep));
      chk("bp_hidden", 64'(hid[2]), 64'(eh));
      @(negedge clk);
    end
    release_out();

    // Reset during L2.
    f = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1;
    features = f;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_out_valid_%0d", k), {63'd0, vld[k]}, 64'd0);
      chk($sformatf("mid_rst_in_ready_%0d", k), {63'd0, rdy[k]}, 64'd1);
      chk($sformatf("mid_rst_hidden_%0d", k), 64'(hid[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    f = {$urandom, $urandom};
    accept_and_wait(f);
    check_all(f);
    release_out();

    // Back-to-back with out_ready held high.
    first = -1;
    second = -1;
    @(negedge clk);
    features = {$urandom, $urandom};
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (vld[0]) begin
        if (first < 0) first = t;
        else if (second < 0) second = t;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_first", 64'(first), 64'd16);
    chk("b2b_period", 64'(second - first), 64'd17);

    // Randomized against the model.
    for (int n = 0; n < 25; n++) begin
      f = {$urandom, $urandom};
      if (n % 5 == 0) f = f & {16{4'($urandom_range(0, 15))}};
      accept_and_wait(f);
      check_all(f);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("rnd_hold_valid", {63'd0, vld[2]}, 64'd1);
      release_out();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
